// File: rtl/dual_pkg.sv
// Shared definitions for the dual-issue WB register file.
// Holds the default data/index widths, the hardwired zero index and the
// bundle type that carries one WB write (enable, destination, data).
package dual_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_wr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the WB register file.
// Forces index 0 to read zero. When WB_REGFILE_BYPASS_EN is defined, a read of
// an index being written this cycle returns the incoming data (inst1 before
// inst0). Otherwise only the stored word is returned.
// The write bundles are expected to be pre-qualified (en already excludes
// r0 and writes blocked around reset).
module regfile_read_port #(
  parameter int DATA_W = dual_pkg::DATA_W,
  parameter int ADDR_W = dual_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  dual_pkg::wb_wr_t  wr0,
  input  dual_pkg::wb_wr_t  wr1,
  output logic [DATA_W-1:0] rd_data
);

  // Select stored word, optional write-through value, then clamp r0 to zero.
  always_comb begin
    rd_data = stored_data;
`ifdef WB_REGFILE_BYPASS_EN
    if (wr1.en && (wr1.dest == rd_addr)) begin
      rd_data = wr1.data;
    end else if (wr0.en && (wr0.dest == rd_addr)) begin
      rd_data = wr0.data;
    end
`endif
    if (rd_addr == ADDR_W'(dual_pkg::REG_ZERO)) begin
      rd_data = '0;
    end
  end

`ifndef WB_REGFILE_BYPASS_EN
  // Write bundles only matter for write-through; fold them away here.
  logic unused_wr;
  assign unused_wr = ^{wr0, wr1};
`endif

endmodule

// File: rtl/wb_dual_regfile.sv
// Architectural register file fed by both MEM/WB pipes of the dual-issue core.
// Two write ports (inst0 older, inst1 younger), four combinational read ports
// (0,1 = slot0 rs/rt; 2,3 = slot1 rs/rt). r0 is hardwired to zero.
// On a same-destination dual write inst1 wins, only one write is performed and
// wr_conflict pulses for the following cycle.
// Optional macro WB_REGFILE_BYPASS_EN: write-through reads of the current WB
// writes (inst1 priority); without it reads return stored contents only.
// Widths default to dual_pkg values; the write bundle type follows the package
// widths, so overrides must keep DATA_W/ADDR_W equal to the package values.
// NUM_REGS must equal 2**ADDR_W.
module wb_dual_regfile #(
  parameter int DATA_W   = dual_pkg::DATA_W,
  parameter int ADDR_W   = dual_pkg::ADDR_W,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteEn_inst0_WB,
  input  logic [ADDR_W-1:0] dest_reg_inst0_WB,
  input  logic [DATA_W-1:0] writeData_inst0_WB,
  input  logic              RegWriteEn_inst1_WB,
  input  logic [ADDR_W-1:0] dest_reg_inst1_WB,
  input  logic [DATA_W-1:0] writeData_inst1_WB,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] rd_addr3,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  output logic              wr_conflict
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Low from reset until the first clk edge that sees reset high, so writes
  // presented on the release edge are dropped.
  logic wr_armed;

  dual_pkg::wb_wr_t wr0;
  dual_pkg::wb_wr_t wr1;
  logic             same_dest;

  logic [ADDR_W-1:0] rd_addr_a [4];
  logic [DATA_W-1:0] rd_data_a [4];

  // Qualify each WB write: armed, enabled and not targeting r0; flag same-dest pairs.
  always_comb begin
    wr0.en    = wr_armed && RegWriteEn_inst0_WB &&
                (dest_reg_inst0_WB != ADDR_W'(dual_pkg::REG_ZERO));
    wr0.dest  = dest_reg_inst0_WB;
    wr0.data  = writeData_inst0_WB;
    wr1.en    = wr_armed && RegWriteEn_inst1_WB &&
                (dest_reg_inst1_WB != ADDR_W'(dual_pkg::REG_ZERO));
    wr1.dest  = dest_reg_inst1_WB;
    wr1.data  = writeData_inst1_WB;
    same_dest = wr0.en && wr1.en && (wr0.dest == wr1.dest);
  end

  // Arm writes one edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_armed <= 1'b0;
    end else begin
      wr_armed <= 1'b1;
    end
  end

  // Storage: async clear, inst0 write suppressed when inst1 hits the same index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0.en && !same_dest) begin
        regs[wr0.dest] <= wr0.data;
      end
      if (wr1.en) begin
        regs[wr1.dest] <= wr1.data;
      end
    end
  end

  // One-cycle pulse reflecting the same-dest condition of the last edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= same_dest;
    end
  end

  // Gather the four read ports into arrays for the generate loop.
  always_comb begin
    rd_addr_a[0] = rd_addr0;
    rd_addr_a[1] = rd_addr1;
    rd_addr_a[2] = rd_addr2;
    rd_addr_a[3] = rd_addr3;
  end

  for (genvar p = 0; p < 4; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .rd_addr     (rd_addr_a[p]),
      .stored_data (regs[rd_addr_a[p]]),
      .wr0         (wr0),
      .wr1         (wr1),
      .rd_data     (rd_data_a[p])
    );
  end

  // Drive the named read outputs from the port array.
  always_comb begin
    rd_data0 = rd_data_a[0];
    rd_data1 = rd_data_a[1];
    rd_data2 = rd_data_a[2];
    rd_data3 = rd_data_a[3];
  end

endmodule

// File: tb/tb_wb_dual_regfile.sv
// Directed bench for wb_dual_regfile. Expected values are hand-computed;
// the same-cycle read expectation follows WB_REGFILE_BYPASS_EN.
module tb_wb_dual_regfile;

  logic        clk;
  logic        reset;
  logic        we0;
  logic [4:0]  dest0;
  logic [31:0] wd0;
  logic        we1;
  logic [4:0]  dest1;
  logic [31:0] wd1;
  logic [4:0]  ra0, ra1, ra2, ra3;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        wr_conflict;

  int checks = 0;
  int errors = 0;

  wb_dual_regfile dut (
    .clk                 (clk),
    .reset               (reset),
    .RegWriteEn_inst0_WB (we0),
    .dest_reg_inst0_WB   (dest0),
    .writeData_inst0_WB  (wd0),
    .RegWriteEn_inst1_WB (we1),
    .dest_reg_inst1_WB   (dest1),
    .writeData_inst1_WB  (wd1),
    .rd_addr0            (ra0),
    .rd_addr1            (ra1),
    .rd_addr2            (ra2),
    .rd_addr3            (ra3),
    .rd_data0            (rd0),
    .rd_data1            (rd1),
    .rd_data2            (rd2),
    .rd_data3            (rd3),
    .wr_conflict         (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic e0, input logic [4:0] d0, input logic [31:0] v0,
                        input logic e1, input logic [4:0] d1, input logic [31:0] v1);
    we0 = e0; dest0 = d0; wd0 = v0;
    we1 = e1; dest1 = d1; wd1 = v1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    ra0 = a0; ra1 = a1; ra2 = a2; ra3 = a3;
  endtask

  initial begin
    reset = 1'b0;
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rd(5'd1, 5'd2, 5'd3, 5'd4);
    #1;
    check("por_rd0", rd0, 32'h0);
    check("por_conflict", {31'b0, wr_conflict}, 32'h0);

    #11 reset = 1'b1;
    step();

    // Preload non-zero registers, including a conflicting pair on r4.
    set_wr(1'b1, 5'd1, 32'h0000_0011, 1'b1, 5'd2, 32'h0000_0022);
    step();
    set_wr(1'b1, 5'd4, 32'h0000_000A, 1'b1, 5'd4, 32'h0000_000B);
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rd(5'd1, 5'd2, 5'd4, 5'd4);
    #1;
    check("pre_r1", rd0, 32'h0000_0011);
    check("pre_r2", rd1, 32'h0000_0022);
    check("pre_r4", rd2, 32'h0000_000B);
    check("pre_conflict", {31'b0, wr_conflict}, 32'h1);

    // Test 1: async reset clears everything before any clk edge.
    #1 reset = 1'b0;
    #1;
    check("t1_rd0", rd0, 32'h0);
    check("t1_rd1", rd1, 32'h0);
    check("t1_rd2", rd2, 32'h0);
    check("t1_rd3", rd3, 32'h0);
    check("t1_conflict", {31'b0, wr_conflict}, 32'h0);
    #1 reset = 1'b1;
    step();

    // Test 2: independent dual write, cross-slot reads.
    set_wr(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd6, 32'h1234_5678);
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rd(5'd5, 5'd6, 5'd5, 5'd6);
    #1;
    check("t2_rd0_r5", rd0, 32'hDEAD_BEEF);
    check("t2_rd3_r6", rd3, 32'h1234_5678);
    check("t2_rd1_r6", rd1, 32'h1234_5678);
    check("t2_rd2_r5", rd2, 32'hDEAD_BEEF);
    check("t2_conflict", {31'b0, wr_conflict}, 32'h0);

    // Test 3: same-dest dual write, inst1 wins, one-cycle conflict pulse.
    set_wr(1'b1, 5'd7, 32'h0000_0001, 1'b1, 5'd7, 32'h0000_0002);
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rd(5'd7, 5'd7, 5'd7, 5'd7);
    #1;
    check("t3_rd0_r7", rd0, 32'h0000_0002);
    check("t3_rd3_r7", rd3, 32'h0000_0002);
    check("t3_conflict_on", {31'b0, wr_conflict}, 32'h1);
    step();
    check("t3_conflict_off", {31'b0, wr_conflict}, 32'h0);
    check("t3_r7_hold", rd1, 32'h0000_0002);

    // Test 4: writes to r0 from both slots are discarded, no conflict.
    set_wr(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(5'd0, 5'd0, 5'd7, 5'd0);
    #1;
    check("t4_r0_during", rd0, 32'h0);
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("t4_r0_after", rd0, 32'h0);
    check("t4_r0_port3", rd3, 32'h0);
    check("t4_r7_intact", rd2, 32'h0000_0002);
    check("t4_conflict", {31'b0, wr_conflict}, 32'h0);

    // Test 5: same-cycle read of r9 while it is being written.
    set_wr(1'b1, 5'd9, 32'h0000_1111, 1'b1, 5'd3, 32'h0000_0099);
    step();
    set_wr(1'b1, 5'd9, 32'h0000_ABCD, 1'b0, 5'd0, 32'h0);
    set_rd(5'd9, 5'd3, 5'd9, 5'd9);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("t5_same_cycle", rd0, 32'h0000_ABCD);
`else
    check("t5_same_cycle", rd0, 32'h0000_1111);
`endif
    check("t5_r3_stored", rd1, 32'h0000_0099);
    set_wr(1'b1, 5'd9, 32'h0000_ABCD, 1'b1, 5'd9, 32'h0000_5555);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("t5_inst1_prio", rd2, 32'h0000_5555);
`else
    check("t5_inst1_prio", rd2, 32'h0000_1111);
`endif
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("t5_r9_after", rd3, 32'h0000_5555);
    check("t5_conflict", {31'b0, wr_conflict}, 32'h1);

    // Test 6: reset in the cycle of a pending dual write to r3.
    set_wr(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd3, 32'h0000_0044);
    set_rd(5'd3, 5'd3, 5'd9, 5'd3);
    #2 reset = 1'b0;
    #1;
    check("t6_r3_in_reset", rd0, 32'h0);
    check("t6_r9_in_reset", rd2, 32'h0);
    step();
    check("t6_r3_edge_in_reset", rd1, 32'h0);
    check("t6_conflict_in_reset", {31'b0, wr_conflict}, 32'h0);
    #2 reset = 1'b1;
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("t6_release_edge_ignored", rd0, 32'h0);
    check("t6_release_conflict", {31'b0, wr_conflict}, 32'h0);
    set_wr(1'b1, 5'd3, 32'h0000_0077, 1'b0, 5'd0, 32'h0);
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("t6_first_write", rd3, 32'h0000_0077);
    check("t6_first_write_conflict", {31'b0, wr_conflict}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
